verify_load_ctrl: RTL and testbench

- Receive-side controller inside combined_top for verify mode (mode=1).
- Accepts the 64-bit valid/ready input stream in fixed order: rho, c, z, t1, mlen, m, h.
- Tags each word with field id and word index for the unpack/storage logic.
- Returns the accept/reject verdict on the 64-bit output stream.

---
 rtl/dilithium_verify_pkg.sv | 57 +++++
 rtl/verify_load_ctrl_if.sv | 46 ++++
 rtl/verify_load_ctrl_word_cnt.sv | 27 ++
 rtl/verify_load_ctrl.sv | 154 +++++++++++++++
 tb/tb_verify_load_ctrl.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dilithium_verify_pkg.sv
// Shared constants and types for the verify-mode receive path:
// field identifiers, per-level word counts, FSM state encoding and
// the byte-mask helper used on the final message word.
package dilithium_verify_pkg;

  localparam int MAX_MLEN_DEF = 3300;
  localparam int IDX_W_DEF    = 10;

  // Field identifiers carried on f_sel.
  localparam logic [2:0] F_RHO  = 3'd0;
  localparam logic [2:0] F_C    = 3'd1;
  localparam logic [2:0] F_Z    = 3'd2;
  localparam logic [2:0] F_T1   = 3'd3;
  localparam logic [2:0] F_MLEN = 3'd4;
  localparam logic [2:0] F_M    = 3'd5;
  localparam logic [2:0] F_H    = 3'd6;

  // Fixed-size fields.
  localparam int RHO_WORDS  = 4;
  localparam int C_WORDS    = 4;
  localparam int MLEN_WORDS = 1;

  // Level-dependent field sizes in 64-bit words.
  localparam int Z_WORDS_L2  = 288;
  localparam int Z_WORDS_L3  = 400;
  localparam int Z_WORDS_L5  = 560;
  localparam int T1_WORDS_L2 = 160;
  localparam int T1_WORDS_L3 = 240;
  localparam int T1_WORDS_L5 = 320;
  localparam int H_WORDS_L2  = 11;
  localparam int H_WORDS_L3  = 8;
  localparam int H_WORDS_L5  = 11;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_RHO      = 4'd1,
    S_C        = 4'd2,
    S_Z        = 4'd3,
    S_T1       = 4'd4,
    S_MLEN     = 4'd5,
    S_M        = 4'd6,
    S_H        = 4'd7,
    S_WAIT_RES = 4'd8,
    S_OUT      = 4'd9
  } state_t;

  // Keeps the first nb bytes of a word (first byte lives at [63:56]).
  function automatic logic [63:0] byte_mask(input logic [3:0] nb);
    logic [63:0] mask;
    mask = '0;
    for (int b = 0; b < 8; b++) begin
      if (b < int'(nb)) mask[63-8*b -: 8] = 8'hFF;
    end
    return mask;
  endfunction

endpackage

// File: rtl/verify_load_ctrl_if.sv
// Bundles the three streams around the verify load controller:
// host input words, tagged words to storage, and verdict in/out.
//
// Handshake rule for every stream here: a transfer happens on a rising
// clock edge where valid and ready are both high; a source holds its
// valid and payload stable until that edge, and ready may depend
// combinationally on valid.
interface verify_load_ctrl_if #(parameter int IDX_W = 10);

  // Host -> controller input stream.
  logic              valid_i;
  logic              ready_i;
  logic [63:0]       data_i;

  // Controller -> storage tagged stream.
  logic              f_valid;
  logic              f_ready;
  logic [2:0]        f_sel;
  logic [IDX_W-1:0]  f_idx;
  logic [63:0]       f_data;
  logic [3:0]        f_nbytes;
  logic              f_last;

  // Core verdict -> controller.
  logic              res_valid;
  logic              res_reject;
  logic              res_ready;

  // Controller -> host result stream.
  logic              valid_o;
  logic              ready_o;
  logic [63:0]       data_o;

  modport slave (
    input  valid_i, data_i, f_ready, res_valid, res_reject, ready_o,
    output ready_i, f_valid, f_sel, f_idx, f_data, f_nbytes, f_last,
           res_ready, valid_o, data_o
  );

  modport master (
    output valid_i, data_i, f_ready, res_valid, res_reject, ready_o,
    input  ready_i, f_valid, f_sel, f_idx, f_data, f_nbytes, f_last,
           res_ready, valid_o, data_o
  );

endinterface

// File: rtl/verify_load_ctrl_word_cnt.sv
// Word counter shared by all fields: counts accepted beats, flags the
// last word against a programmable terminal count and wraps to 0 on it.
module vld_word_cnt #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         beat,
  input  logic [W-1:0] term,
  output logic [W-1:0] idx,
  output logic         last
);

  // Terminal count is always >= 1, so term-1 never underflows.
  assign last = (idx == (term - W'(1)));

  // Advance on each beat; wrap on the last word of the field.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx <= '0;
    end else if (beat) begin
      if (last) idx <= '0;
      else      idx <= idx + W'(1);
    end
  end

endmodule

// File: rtl/verify_load_ctrl.sv
// Verify-mode receive controller: walks the fixed field order
// rho, c, z, t1, mlen, m, h, tags each word with field id and index,
// masks the tail of the message, then returns the core's verdict.
module verify_load_ctrl
  import dilithium_verify_pkg::*;
#(
  parameter int MAX_MLEN = MAX_MLEN_DEF,
  parameter int IDX_W    = IDX_W_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [2:0]          sec_lvl,
  verify_load_ctrl_if.slave   bus,
  output logic [15:0]         mlen_o,
  output logic                busy,
  output state_t              dbg_state
);

  state_t           state, state_nxt;
  logic [2:0]       lvl;
  logic             load;
  logic             beat;
  logic [IDX_W-1:0] term;
  logic [IDX_W-1:0] idx;
  logic             last;
  logic             lvl_ok;
  logic [15:0]      m_rem;
  logic [3:0]       nbytes;

  // Number of message words: ceil(mlen/8), at least one word.
  function automatic logic [IDX_W-1:0] m_words(input logic [15:0] mlen);
    logic [16:0] w;
    w = ({1'b0, mlen} + 17'd7) >> 3;
    if (w == 17'd0) return IDX_W'(1);
    return IDX_W'(w);
  endfunction

  assign lvl_ok    = (sec_lvl == 3'd2) || (sec_lvl == 3'd3) || (sec_lvl == 3'd5);
  assign load      = (state >= S_RHO) && (state <= S_H);
  assign beat      = load && bus.valid_i && bus.f_ready;
  assign busy      = (state != S_IDLE);
  assign dbg_state = state;

  // Terminal word count for the field currently being loaded.
  always_comb begin
    term = IDX_W'(1);
    unique case (state)
      S_RHO:  term = IDX_W'(RHO_WORDS);
      S_C:    term = IDX_W'(C_WORDS);
      S_Z:    term = (lvl == 3'd2) ? IDX_W'(Z_WORDS_L2) :
                     (lvl == 3'd3) ? IDX_W'(Z_WORDS_L3) : IDX_W'(Z_WORDS_L5);
      S_T1:   term = (lvl == 3'd2) ? IDX_W'(T1_WORDS_L2) :
                     (lvl == 3'd3) ? IDX_W'(T1_WORDS_L3) : IDX_W'(T1_WORDS_L5);
      S_MLEN: term = IDX_W'(MLEN_WORDS);
      S_M:    term = m_words(mlen_o);
      S_H:    term = (lvl == 3'd3) ? IDX_W'(H_WORDS_L3) :
                     (lvl == 3'd2) ? IDX_W'(H_WORDS_L2) : IDX_W'(H_WORDS_L5);
      default: term = IDX_W'(1);
    endcase
  end

  vld_word_cnt #(.W(IDX_W)) u_word_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .beat  (beat),
    .term  (term),
    .idx   (idx),
    .last  (last)
  );

  // Bytes left for the final message word; 0 only when mlen is 0.
  assign m_rem = mlen_o - 16'({idx, 3'b000});

  // Tagged-stream outputs and input handshake pass-through.
  always_comb begin
    bus.f_valid  = 1'b0;
    bus.ready_i  = 1'b0;
    bus.f_sel    = F_RHO;
    bus.f_idx    = idx;
    bus.f_data   = '0;
    bus.f_last   = 1'b0;
    nbytes       = 4'd0;
    if (load) begin
      bus.f_valid = bus.valid_i;
      bus.ready_i = bus.f_ready;
      bus.f_last  = last;
      nbytes      = 4'd8;
      bus.f_data  = bus.data_i;
      unique case (state)
        S_RHO:  bus.f_sel = F_RHO;
        S_C:    bus.f_sel = F_C;
        S_Z:    bus.f_sel = F_Z;
        S_T1:   bus.f_sel = F_T1;
        S_MLEN: bus.f_sel = F_MLEN;
        S_M:    bus.f_sel = F_M;
        default: bus.f_sel = F_H;
      endcase
      if (state == S_M && last) begin
        nbytes     = m_rem[3:0];
        bus.f_data = bus.data_i & byte_mask(m_rem[3:0]);
      end
    end
  end

  assign bus.f_nbytes  = nbytes;
  assign bus.res_ready = (state == S_WAIT_RES);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state: advance through the fields on each field's last beat.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:     if (start && lvl_ok) state_nxt = S_RHO;
      S_RHO:      if (beat && last) state_nxt = S_C;
      S_C:        if (beat && last) state_nxt = S_Z;
      S_Z:        if (beat && last) state_nxt = S_T1;
      S_T1:       if (beat && last) state_nxt = S_MLEN;
      S_MLEN:     if (beat && last) state_nxt = S_M;
      S_M:        if (beat && last) state_nxt = S_H;
      S_H:        if (beat && last) state_nxt = S_WAIT_RES;
      S_WAIT_RES: if (bus.res_valid) state_nxt = S_OUT;
      S_OUT:      if (bus.ready_o) state_nxt = S_IDLE;
      default:    state_nxt = S_IDLE;
    endcase
  end

  // Level latch, saturated mlen and the registered verdict word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lvl         <= 3'd0;
      mlen_o      <= 16'd0;
      bus.valid_o <= 1'b0;
      bus.data_o  <= 64'd0;
    end else begin
      if (state == S_IDLE && start && lvl_ok) lvl <= sec_lvl;
      if (state == S_MLEN && beat) begin
        mlen_o <= (bus.data_i[15:0] > 16'(MAX_MLEN)) ? 16'(MAX_MLEN) : bus.data_i[15:0];
      end
      if (state == S_WAIT_RES && bus.res_valid) begin
        bus.valid_o <= 1'b1;
        bus.data_o  <= {63'd0, bus.res_reject};
      end else if (state == S_OUT && bus.ready_o) begin
        bus.valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_verify_load_ctrl.sv
// Directed bench for verify_load_ctrl: full loads at each level,
// backpressure, mlen edge cases, level filtering, mid-load reset and
// verdict holding on the result stream.
module tb_verify_load_ctrl;
  import dilithium_verify_pkg::*;

  localparam int IDX_W = 10;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [2:0]  sec_lvl;
  logic [15:0] mlen_o;
  logic        busy;
  state_t      dbg_state;

  int errors = 0;
  int checks = 0;
  int beats  = 0;

  verify_load_ctrl_if #(.IDX_W(IDX_W)) bus ();

  verify_load_ctrl #(.MAX_MLEN(3300), .IDX_W(IDX_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .sec_lvl   (sec_lvl),
    .bus       (bus.slave),
    .mlen_o    (mlen_o),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // Clock: 10 ns period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic pulse_start(input logic [2:0] lvl_in);
    @(negedge clk);
    start   = 1'b1;
    sec_lvl = lvl_in;
    @(negedge clk);
    start   = 1'b0;
  endtask

  // Streams words of one field; 'send' may stop short of 'n' words.
  task automatic drive_field(input logic [2:0] sel, input int n, input int send,
                             input bit toggle, input int mlen_v);
    int i;
    int cyc;
    int nb;
    logic [63:0] d;
    logic [63:0] exp_d;
    logic [63:0] m;
    logic        exp_last;
    i = 0;
    cyc = 0;
    while (i < send && cyc < 4 * send + 8) begin
      @(negedge clk);
      d = {$urandom, $urandom};
      if (sel == F_MLEN) d[15:0] = 16'(mlen_v);
      bus.valid_i = 1'b1;
      bus.data_i  = d;
      bus.f_ready = toggle ? (cyc % 2 == 1) : 1'b1;
      #1;
      nb = 8;
      exp_d = d;
      exp_last = (i == n - 1);
      if (sel == F_M && i == n - 1) begin
        nb = mlen_v - 8 * i;
        m = '0;
        for (int b = 0; b < nb; b++) m[63-8*b -: 8] = 8'hFF;
        exp_d = d & m;
      end
      checks++;
      if (bus.f_valid !== 1'b1 || bus.f_sel !== sel || bus.f_idx !== IDX_W'(i) ||
          bus.f_last !== exp_last || bus.f_data !== exp_d ||
          bus.f_nbytes !== 4'(nb) || bus.ready_i !== bus.f_ready) begin
        errors++;
        $display("FAIL word f%0d/%0d: got v=%b sel=%0d idx=%0d last=%b nb=%0d data=%h rdy=%b, want sel=%0d idx=%0d last=%b nb=%0d data=%h rdy=%b",
                 sel, i, bus.f_valid, bus.f_sel, bus.f_idx, bus.f_last, bus.f_nbytes,
                 bus.f_data, bus.ready_i, sel, i, exp_last, nb, exp_d, bus.f_ready);
      end
      if (bus.f_ready) begin
        i++;
        beats++;
      end
      cyc++;
    end
    checks++;
    if (i < send) begin
      errors++;
      $display("FAIL field_timeout f%0d: sent %0d, required %0d", sel, i, send);
    end
  endtask

  // Full load of all seven fields with bench-side word counts.
  task automatic load_all(input logic [2:0] lvl_in, input int mlen_raw, input bit toggle);
    int zc, tc, hc, ms, mw;
    zc = (lvl_in == 3'd2) ? 288 : (lvl_in == 3'd3) ? 400 : 560;
    tc = (lvl_in == 3'd2) ? 160 : (lvl_in == 3'd3) ? 240 : 320;
    hc = (lvl_in == 3'd3) ? 8 : 11;
    ms = (mlen_raw > 3300) ? 3300 : mlen_raw;
    mw = (ms + 7) / 8;
    if (mw == 0) mw = 1;
    drive_field(F_RHO, 4, 4, toggle, 0);
    drive_field(F_C, 4, 4, toggle, 0);
    drive_field(F_Z, zc, zc, toggle, 0);
    drive_field(F_T1, tc, tc, toggle, 0);
    drive_field(F_MLEN, 1, 1, toggle, mlen_raw);
    drive_field(F_M, mw, mw, toggle, ms);
    checks++;
    if (mlen_o !== 16'(ms)) begin
      errors++;
      $display("FAIL mlen_o: got %0d, want %0d", mlen_o, ms);
    end
    drive_field(F_H, hc, hc, toggle, 0);
  endtask

  // Delivers a verdict and drains it, holding ready_o low 'hold' cycles.
  task automatic test_verdict(input bit rej, input int hold);
    int w;
    @(negedge clk);
    bus.valid_i = 1'b0;
    #1;
    w = 0;
    while (bus.res_ready !== 1'b1 && w < 20) begin
      @(negedge clk);
      #1;
      w++;
    end
    checks++;
    if (bus.res_ready !== 1'b1 || dbg_state !== S_WAIT_RES) begin
      errors++;
      $display("FAIL wait_res: got res_ready=%b state=%0d, want 1 and %0d", bus.res_ready, dbg_state, S_WAIT_RES);
    end
    bus.res_valid  = 1'b1;
    bus.res_reject = rej;
    bus.ready_o    = (hold == 0);
    @(negedge clk);
    bus.res_valid  = 1'b0;
    bus.res_reject = ~rej;
    #1;
    checks++;
    if (bus.valid_o !== 1'b1 || bus.data_o !== 64'(rej) || bus.res_ready !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL verdict: got valid_o=%b data_o=%h res_ready=%b busy=%b, want 1 %h 0 1",
               bus.valid_o, bus.data_o, bus.res_ready, busy, 64'(rej));
    end
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      #1;
      checks++;
      if (bus.valid_o !== 1'b1 || bus.data_o !== 64'(rej)) begin
        errors++;
        $display("FAIL verdict_hold%0d: got valid_o=%b data_o=%h, want 1 %h", k, bus.valid_o, bus.data_o, 64'(rej));
      end
    end
    bus.ready_o = 1'b1;
    @(negedge clk);
    bus.ready_o = 1'b0;
    #1;
    checks++;
    if (bus.valid_o !== 1'b0 || busy !== 1'b0 || dbg_state !== S_IDLE) begin
      errors++;
      $display("FAIL verdict_done: got valid_o=%b busy=%b state=%0d, want 0 0 0", bus.valid_o, busy, dbg_state);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    bus.valid_i = 1'b1;
    bus.f_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || bus.valid_o !== 1'b0 || bus.data_o !== 64'd0 || bus.res_ready !== 1'b0 ||
        mlen_o !== 16'd0 || bus.ready_i !== 1'b0 || bus.f_valid !== 1'b0 || dbg_state !== S_IDLE) begin
      errors++;
      $display("FAIL reset: got busy=%b valid_o=%b data_o=%h res_ready=%b mlen=%0d ready_i=%b f_valid=%b, want all 0",
               busy, bus.valid_o, bus.data_o, bus.res_ready, mlen_o, bus.ready_i, bus.f_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    bus.valid_i = 1'b0;
  endtask

  task automatic test_l2_load;
    beats = 0;
    pulse_start(3'd2);
    load_all(3'd2, 33, 1'b0);
    checks++;
    if (beats !== 473) begin
      errors++;
      $display("FAIL l2_beats: got %0d, want 473", beats);
    end
    test_verdict(1'b0, 0);
  endtask

  task automatic test_l3_backpressure;
    pulse_start(3'd3);
    load_all(3'd3, 20, 1'b1);
    test_verdict(1'b1, 0);
  endtask

  task automatic test_l5_mlen0;
    beats = 0;
    pulse_start(3'd5);
    load_all(3'd5, 0, 1'b0);
    checks++;
    if (beats !== 4 + 4 + 560 + 320 + 1 + 1 + 11) begin
      errors++;
      $display("FAIL l5_beats: got %0d, want %0d", beats, 4 + 4 + 560 + 320 + 1 + 1 + 11);
    end
    test_verdict(1'b1, 0);
  endtask

  task automatic test_bad_level;
    bus.valid_i = 1'b1;
    bus.f_ready = 1'b1;
    pulse_start(3'd4);
    #1;
    checks++;
    if (busy !== 1'b0 || bus.ready_i !== 1'b0) begin
      errors++;
      $display("FAIL bad_level: got busy=%b ready_i=%b, want 0 0", busy, bus.ready_i);
    end
    bus.valid_i = 1'b0;
    pulse_start(3'd2);
    #1;
    checks++;
    if (busy !== 1'b1 || dbg_state !== S_RHO) begin
      errors++;
      $display("FAIL good_level: got busy=%b state=%0d, want 1 %0d", busy, dbg_state, S_RHO);
    end
    pulse_start(3'd3);
    #1;
    checks++;
    if (dbg_state !== S_RHO || bus.f_idx !== '0) begin
      errors++;
      $display("FAIL start_ignored: got state=%0d idx=%0d, want %0d 0", dbg_state, bus.f_idx, S_RHO);
    end
  endtask

  task automatic test_mid_reset;
    drive_field(F_RHO, 4, 4, 1'b0, 0);
    drive_field(F_C, 4, 4, 1'b0, 0);
    drive_field(F_Z, 288, 100, 1'b0, 0);
    @(negedge clk);
    bus.valid_i = 1'b1;
    #1;
    checks++;
    if (bus.f_idx !== IDX_W'(100) || bus.f_sel !== F_Z) begin
      errors++;
      $display("FAIL z_idx100: got sel=%0d idx=%0d, want 2 100", bus.f_sel, bus.f_idx);
    end
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || bus.valid_o !== 1'b0 || bus.f_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: got busy=%b valid_o=%b f_valid=%b, want 0 0 0", busy, bus.valid_o, bus.f_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    bus.valid_i = 1'b0;
  endtask

  task automatic test_back_to_back_hold;
    pulse_start(3'd2);
    load_all(3'd2, 5000, 1'b0);
    test_verdict(1'b1, 3);
  endtask

  initial begin
    rst_n          = 1'b0;
    start          = 1'b0;
    sec_lvl        = 3'd0;
    bus.valid_i    = 1'b0;
    bus.data_i     = '0;
    bus.f_ready    = 1'b0;
    bus.res_valid  = 1'b0;
    bus.res_reject = 1'b0;
    bus.ready_o    = 1'b0;
    test_reset();
    test_l2_load();
    test_l3_backpressure();
    test_l5_mlen0();
    test_bad_level();
    test_mid_reset();
    test_back_to_back_hold();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
